// File: rtl/stream_downsizer.sv
// Wide-to-narrow stream converter: each wide word leaves as 1..RATIO narrow beats, slice 0 first.
// Latency one cycle; input is accepted only when empty or when the final beat is taken downstream.
module stream_downsizer #(
    parameter int OUT_WIDTH   = 32,
    parameter int RATIO       = 4,
    parameter int BWIDTH      = 3,
    parameter int TLAST_WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [OUT_WIDTH*RATIO-1:0]   s_in_tdata,
    input  logic [BWIDTH-1:0]            s_in_tbeats,
    input  logic                         s_in_tvalid,
    output logic                         s_in_tready,
    input  logic [TLAST_WIDTH-1:0]       s_in_tlast,
    output logic [OUT_WIDTH-1:0]         m_out_tdata,
    output logic                         m_out_tvalid,
    input  logic                         m_out_tready,
    output logic [TLAST_WIDTH-1:0]       m_out_tlast
);

    localparam int IDXW = $clog2(RATIO);
    localparam int DW   = OUT_WIDTH * RATIO;

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    // The beat count is kept as the index of the final slice so the compare stays narrow.
    typedef struct packed {
        logic [DW-1:0]          data;
        logic [TLAST_WIDTH-1:0] last;
        logic [IDXW-1:0]        last_idx;
    } hold_t;

    state_t            state, state_nxt;
    hold_t             hold, hold_in;
    logic [IDXW-1:0]   idx, idx_nxt;
    logic [BWIDTH-1:0] beats_sat;
    logic              loaded;
    logic              final_beat;
    logic              in_hs;
    logic              out_hs;
    logic              load;

    assign loaded       = (state == SEND);
    assign final_beat   = (idx == hold.last_idx);
    assign s_in_tready  = rst_n & (~loaded | (final_beat & m_out_tready));
    assign in_hs        = s_in_tvalid & s_in_tready;
    assign out_hs       = m_out_tvalid & m_out_tready;
    assign m_out_tvalid = loaded;
    assign m_out_tdata  = hold.data[int'(idx)*OUT_WIDTH +: OUT_WIDTH];
    assign m_out_tlast  = final_beat ? hold.last : '0;

    always_comb begin
        beats_sat = s_in_tbeats;
        if (s_in_tbeats == '0 || int'(s_in_tbeats) > RATIO) begin
            beats_sat = BWIDTH'(RATIO);
        end
        hold_in.data     = s_in_tdata;
        hold_in.last     = s_in_tlast;
        hold_in.last_idx = IDXW'(beats_sat - BWIDTH'(1));
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_hs) begin
                    load      = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_hs) begin
                    if (!final_beat) begin
                        idx_nxt = idx + IDXW'(1);
                    end else if (in_hs) begin
                        load    = 1'b1;
                        idx_nxt = '0;
                    end else begin
                        idx_nxt   = '0;
                        state_nxt = EMPTY;
                    end
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            idx   <= '0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (load) begin
                hold <= hold_in;
            end
        end
    end

endmodule
